// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a one-entry output buffer.
//
// Keeps a PC and a request address. It issues one instruction-memory read at
// a time and presents each returned word to decode through a valid/ready
// buffer. A redirect from branch resolution (branch/JSR, trap, JMP) replaces
// the PC and flushes the buffer. If a read is still outstanding, its response
// is waited out in SQUASH and then dropped. The memory address never changes
// under an active read.
//
// Ports
//   clk, reset_n                   clock, synchronous active-low reset
//   redirect_valid, redirect_sel   redirect strobe and PC source
//                                  (00 none, 01 br, 10 trap, 11 jmp)
//   br_target, trap_target,
//   jmp_target                     candidate redirect PCs
//   imem_read, imem_address        memory read request and address
//   imem_rdata, imem_resp          returned word and its one-cycle strobe
//   if_valid, if_pc, if_ir         buffered instruction presented to decode
//   if_ready                       decode accepts the buffered instruction
//   squash_count                   count of discarded fetches
//
// Build option
//   FETCH_SQUASH_COUNT_EN  When defined, squash_count is a saturating count
//                          of dropped responses and flushed buffer entries.
//                          When undefined, squash_count is tied to zero.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_sel,
    input  logic [15:0] br_target,
    input  logic [15:0] trap_target,
    input  logic [15:0] jmp_target,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    output logic        if_valid,
    output logic [15:0] if_pc,
    output logic [15:0] if_ir,
    input  logic        if_ready,
    output logic [15:0] squash_count
);

    typedef enum logic [1:0] {IDLE, REQ, SQUASH} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] req_addr, req_addr_nxt;
    logic        if_valid_nxt;
    logic [15:0] if_pc_nxt, if_ir_nxt;
    logic        redirect, xfer;
    logic [15:0] target;

    // A strobe with sel=00 is not a redirect.
    assign redirect     = redirect_valid && (redirect_sel != 2'b00);
    assign xfer         = if_valid && if_ready;
    assign imem_read    = (state != IDLE);
    assign imem_address = req_addr;

    always_comb begin
        target = br_target;
        case (redirect_sel)
            2'b10:   target = trap_target;
            2'b11:   target = jmp_target;
            default: target = br_target;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        if_valid_nxt = if_valid && !xfer;
        if_pc_nxt    = if_pc;
        if_ir_nxt    = if_ir;

        if (redirect) begin
            pc_nxt       = target;
            if_valid_nxt = 1'b0;
            // The bus is free to start the new target now if no read is
            // pending or the pending read completes this cycle. Otherwise
            // keep the old address on the bus until the response is dropped.
            if (state == IDLE || imem_resp) begin
                req_addr_nxt = target;
                state_nxt    = REQ;
            end else begin
                state_nxt = SQUASH;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!if_valid || xfer) begin
                        req_addr_nxt = pc;
                        state_nxt    = REQ;
                    end
                end
                REQ: begin
                    if (imem_resp) begin
                        if_valid_nxt = 1'b1;
                        if_pc_nxt    = req_addr;
                        if_ir_nxt    = imem_rdata;
                        pc_nxt       = req_addr + 16'd2;
                        state_nxt    = IDLE;
                    end
                end
                SQUASH: begin
                    if (imem_resp) begin
                        req_addr_nxt = pc;
                        state_nxt    = REQ;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_ir    <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            if_valid <= if_valid_nxt;
            if_pc    <= if_pc_nxt;
            if_ir    <= if_ir_nxt;
        end
    end

`ifdef FETCH_SQUASH_COUNT_EN
    logic        discard, flush;
    logic [1:0]  inc;
    logic [16:0] sum;
    logic [15:0] squash_cnt;

    // A response is dropped when it arrives with a redirect, or while in
    // SQUASH. A late response in IDLE is not a read of this block, so it
    // is not counted.
    assign discard = imem_read && imem_resp && (redirect || state == SQUASH);
    // A buffered instruction that decode accepts on the redirect edge was
    // delivered, so it is not counted as flushed.
    assign flush   = redirect && if_valid && !if_ready;
    assign inc     = {1'b0, discard} + {1'b0, flush};
    assign sum     = {1'b0, squash_cnt} + {15'd0, inc};

    always_ff @(posedge clk) begin
        if (!reset_n) squash_cnt <= '0;
        else          squash_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
    end

    assign squash_count = squash_cnt;
`else
    assign squash_count = '0;
`endif

endmodule
